// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state type for the UART command bridge.
package uart_cmd_pkg;

  localparam logic [7:0] OpWrite   = 8'h01;
  localparam logic [7:0] OpRead    = 8'h02;
  localparam logic [7:0] OpEnable  = 8'h03;
  localparam logic [7:0] OpDisable = 8'h04;
  localparam logic [7:0] AckByte   = 8'hAA;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StDhi,
    StDlo,
    StReq,
    StAccess,
    StCapture,
    StResp
  } state_e;

endpackage

// File: rtl/uart_cmd_bridge.sv
// Decodes UART command frames into neuron-memory reads/writes and sys_en control,
// and returns acknowledge or read-data bytes over a valid/ready transmit port.
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NEURON_NUMBER = 256,
  parameter int unsigned NEUR_WIDTH    = 13,
  parameter int unsigned GAP_CYCLES    = 100000,
  parameter bit          SYS_EN_RST    = 1'b1,
  localparam int unsigned AW           = $clog2(NEURON_NUMBER)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  ext_req,
  input  logic                  ext_ack,
  output logic                  ext_we,
  output logic                  ext_re,
  output logic [AW-1:0]         ext_neur_addr,
  output logic [NEUR_WIDTH-1:0] ext_neur_data_in,
  input  logic [NEUR_WIDTH-1:0] ext_neur_data_out,
  output logic                  sys_en,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  cmd_err
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  state_e                state_q, state_d;
  logic                  is_write_q, is_write_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [7:0]            data_hi_q, data_hi_d;
  logic [NEUR_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            rlo_q, rlo_d;
  logic                  more_q, more_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  sys_en_q, sys_en_d;
  logic                  err_q, err_d;

  logic                  in_frame, busy, timeout;
  logic [15:0]           rd16, wd16;

  assign in_frame = (state_q == StAddr) || (state_q == StDhi) || (state_q == StDlo);
  assign busy     = (state_q == StReq) || (state_q == StAccess) ||
                    (state_q == StCapture) || (state_q == StResp);
  assign timeout  = in_frame && !rx_valid && (gap_q >= GW'(GAP_CYCLES - 1));
  assign rd16     = 16'(ext_neur_data_out);
  assign wd16     = {data_hi_q, rx_data};

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    data_hi_d  = data_hi_q;
    wdata_d    = wdata_q;
    rlo_d      = rlo_q;
    more_d     = more_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    sys_en_d   = sys_en_q;
    err_d      = 1'b0;
    // Gap counter saturates at the timeout point and clears on any byte or frame exit.
    gap_d      = (in_frame && !rx_valid && !timeout) ? gap_q + GW'(1) : '0;

    if (busy && rx_valid) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          case (rx_data)
            OpWrite, OpRead: begin
              is_write_d = (rx_data == OpWrite);
              state_d    = StAddr;
            end
            OpEnable, OpDisable: begin
              sys_en_d   = (rx_data == OpEnable);
              tx_valid_d = 1'b1;
              tx_data_d  = AckByte;
              more_d     = 1'b0;
              state_d    = StResp;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StAddr, StDhi, StDlo: begin
        if (rx_valid) begin
          if (state_q == StAddr) begin
            addr_d  = rx_data[AW-1:0];
            state_d = is_write_q ? StDhi : StReq;
          end else if (state_q == StDhi) begin
            data_hi_d = rx_data;
            state_d   = StDlo;
          end else begin
            wdata_d = wd16[NEUR_WIDTH-1:0];
            state_d = StReq;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StReq: begin
        if (ext_ack) state_d = StAccess;
      end
      StAccess: begin
        if (is_write_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = AckByte;
          more_d     = 1'b0;
          state_d    = StResp;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        rlo_d      = rd16[7:0];
        tx_data_d  = rd16[15:8];
        tx_valid_d = 1'b1;
        more_d     = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
        if (tx_valid_q && tx_ready) begin
          if (more_q) begin
            tx_data_d = rlo_q;
            more_d    = 1'b0;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      gap_q      <= '0;
      addr_q     <= '0;
      data_hi_q  <= '0;
      wdata_q    <= '0;
      rlo_q      <= '0;
      more_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      sys_en_q   <= SYS_EN_RST;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      gap_q      <= gap_d;
      addr_q     <= addr_d;
      data_hi_q  <= data_hi_d;
      wdata_q    <= wdata_d;
      rlo_q      <= rlo_d;
      more_q     <= more_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      sys_en_q   <= sys_en_d;
      err_q      <= err_d;
    end
  end

  assign ext_req          = (state_q == StReq) || (state_q == StAccess) || (state_q == StCapture);
  assign ext_we           = (state_q == StAccess) && is_write_q;
  assign ext_re           = (state_q == StAccess) && !is_write_q;
  assign ext_neur_addr    = addr_q;
  assign ext_neur_data_in = wdata_q;
  assign sys_en           = sys_en_q;
  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign cmd_err          = err_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Randomized frame-level bench: a transaction model predicts memory accesses, tx bytes,
// sys_en and error pulses; a per-cycle monitor compares the DUT against it.
module tb_uart_cmd_bridge;
  import uart_cmd_pkg::*;

  localparam int unsigned NN  = 256;
  localparam int unsigned NW  = 13;
  localparam int unsigned GAP = 40;
  localparam int unsigned AW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          ext_req, ext_we, ext_re;
  logic          ext_ack = 1'b0;
  logic [AW-1:0] ext_neur_addr;
  logic [NW-1:0] ext_neur_data_in;
  logic [NW-1:0] ext_neur_data_out = '0;
  logic          sys_en;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          cmd_err;

  uart_cmd_bridge #(
    .NEURON_NUMBER(NN),
    .NEUR_WIDTH   (NW),
    .GAP_CYCLES   (GAP),
    .SYS_EN_RST   (1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .ext_req          (ext_req),
    .ext_ack          (ext_ack),
    .ext_we           (ext_we),
    .ext_re           (ext_re),
    .ext_neur_addr    (ext_neur_addr),
    .ext_neur_data_in (ext_neur_data_in),
    .ext_neur_data_out(ext_neur_data_out),
    .sys_en           (sys_en),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .cmd_err          (cmd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit            we;
    logic [7:0]    addr;
    logic [NW-1:0] data;
  } acc_t;

  acc_t          exp_acc[$];
  logic [7:0]    exp_tx[$];
  logic [NW-1:0] nmem[NN];
  logic [NW-1:0] model_mem[NN];
  acc_t          last_acc;
  int            err_exp = 0, err_seen = 0, we_cnt = 0, re_cnt = 0, req_cycles = 0;
  bit            exp_sys_en = 1'b1;
  int            ack_mode = 1, ready_mode = 1;
  bit            prev_hold = 1'b0;
  logic [7:0]    prev_data = 8'h00;

  // Neuron memory stand-in: registered read data appears the cycle after ext_re.
  always @(posedge clk) begin
    if (ext_re) ext_neur_data_out <= nmem[ext_neur_addr];
    if (ext_we) nmem[ext_neur_addr] = ext_neur_data_in;
  end

  always @(posedge clk) begin
    #2;
    ext_ack  = (ack_mode == 0) ? 1'b0 : (ack_mode == 1) ? 1'b1 : (($urandom % 3) != 0);
    tx_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : (($urandom % 3) != 0);
  end

  always @(negedge clk) begin
    acc_t a;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      chk("sys_en", 32'(sys_en), 32'(exp_sys_en));
      if (cmd_err) err_seen++;
      if (ext_req) req_cycles++;
      if (ext_we || ext_re) begin
        chk("req_with_strobe", 32'(ext_req), 32'd1);
        chk("we_re_excl", 32'(ext_we && ext_re), 32'd0);
        if (ext_we) we_cnt++;
        else re_cnt++;
        chk("acc_expected", 32'(exp_acc.size() != 0), 32'd1);
        if (exp_acc.size() != 0) begin
          a = exp_acc.pop_front();
          last_acc = '{we: ext_we, addr: ext_neur_addr, data: ext_neur_data_in};
          chk("acc_kind", 32'(ext_we), 32'(a.we));
          chk("acc_addr", 32'(ext_neur_addr), 32'(a.addr));
          if (a.we) chk("acc_data", 32'(ext_neur_data_in), 32'(a.data));
        end
      end
      if (prev_hold) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  // All driver tasks start and end one time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_acc.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_done", 32'(exp_tx.size() + exp_acc.size()), 32'd0);
    chk("err_cnt", 32'(err_seen), 32'(err_exp));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] w;
    w = {hi, lo};
    model_mem[a] = w[NW-1:0];
    exp_acc.push_back('{we: 1'b1, addr: a, data: w[NW-1:0]});
    exp_tx.push_back(AckByte);
    send_byte(OpWrite); idle($urandom_range(0, 4));
    send_byte(a);       idle($urandom_range(0, 4));
    send_byte(hi);      idle($urandom_range(0, 4));
    send_byte(lo);
  endtask

  task automatic do_read(input logic [7:0] a);
    logic [15:0] d;
    d = 16'(model_mem[a]);
    exp_acc.push_back('{we: 1'b0, addr: a, data: '0});
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
    send_byte(OpRead); idle($urandom_range(0, 4));
    send_byte(a);
  endtask

  task automatic do_en(input bit en);
    exp_tx.push_back(AckByte);
    send_byte(en ? OpEnable : OpDisable);
    exp_sys_en = en;
  endtask

  initial begin
    int w0;
    logic [31:0] v;
    logic [7:0] op;

    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [31:0] v;
    logic [7:0] op;

    for (int i = 0; i < int'(NN); i++) begin
      v = $urandom;
      nmem[i]      = v[NW-1:0];
      model_mem[i] = v[NW-1:0];
    end
    nmem[8'h10]      = 13'h0ABC;
    model_mem[8'h10] = 13'h0ABC;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ext_req", 32'(ext_req), 32'd0);
    chk("rst_ext_we", 32'(ext_we), 32'd0);
    chk("rst_ext_re", 32'(ext_re), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_addr", 32'(ext_neur_addr), 32'd0);
    chk("rst_wdata", 32'(ext_neur_data_in), 32'd0);
    chk("rst_sys_en", 32'(sys_en), 32'd1);
    reset = 1'b0;
    idle(2);

    // Directed WRITE 01 05 1F FF.
    exp_acc.push_back('{we: 1'b1, addr: 8'h05, data: 13'h1FFF});
    exp_tx.push_back(8'hAA);
    model_mem[8'h05] = 13'h1FFF;
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h1F); send_byte(8'hFF);
    drain();
    chk("w_addr", 32'(last_acc.addr), 32'h05);
    chk("w_data", 32'(last_acc.data), 32'h1FFF);
    chk("w_cnt", 32'(we_cnt), 32'd1);

    // Directed READ 02 10 of 0x0ABC.
    exp_acc.push_back('{we: 1'b0, addr: 8'h10, data: '0});
    exp_tx.push_back(8'h0A);
    exp_tx.push_back(8'hBC);
    send_byte(8'h02); send_byte(8'h10);
    drain();
    chk("r_cnt", 32'(re_cnt), 32'd1);

    // Withheld ack, plus a stray byte while waiting in the request phase.
    ack_mode = 0;
    w0 = we_cnt;
    req_cycles = 0;
    exp_acc.push_back('{we: 1'b1, addr: 8'h22, data: 13'h0077});
    exp_tx.push_back(8'hAA);
    model_mem[8'h22] = 13'h0077;
    send_byte(8'h01); send_byte(8'h22); send_byte(8'h00); send_byte(8'h77);
    idle(3);
    send_byte(8'h55);
    err_exp++;
    idle(50);
    chk("held_no_we", 32'(we_cnt), 32'(w0));
    chk("held_req", 32'(req_cycles >= 50), 32'd1);
    ack_mode = 1;
    drain();
    chk("held_one_we", 32'(we_cnt), 32'(w0 + 1));

    // Inter-byte gap timeout, then a read whose gap sits one cycle short of it.
    w0 = we_cnt + re_cnt;
    send_byte(8'h01); send_byte(8'h05);
    idle(GAP + 5);
    err_exp++;
    chk("to_err", 32'(err_seen), 32'(err_exp));
    chk("to_no_access", 32'(we_cnt + re_cnt), 32'(w0));
    exp_acc.push_back('{we: 1'b0, addr: 8'h10, data: '0});
    exp_tx.push_back(8'h0A);
    exp_tx.push_back(8'hBC);
    send_byte(8'h02);
    idle(GAP - 1);
    send_byte(8'h10);
    drain();

    // Unknown opcode, then DISABLE with tx_ready held low.
    send_byte(8'h07);
    err_exp++;
    idle(2);
    chk("unk_err", 32'(err_seen), 32'(err_exp));
    ready_mode = 0;
    do_en(1'b0);
    idle(20);
    chk("stall_valid", 32'(tx_valid), 32'd1);
    chk("stall_data", 32'(tx_data), 32'hAA);
    chk("dis_sys_en", 32'(sys_en), 32'd0);
    ready_mode = 1;
    drain();

    // Randomized frames with random ack and tx_ready behaviour.
    ack_mode = 2;
    ready_mode = 2;
    for (int f = 0; f < 80; f++) begin
      case ($urandom % 5)
        0, 1: do_write(8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        2:    do_read(8'($urandom_range(0, 15)));
        3:    do_en(1'($urandom));
        default: begin
          op = 8'($urandom);
          if (op >= 8'h01 && op <= 8'h04) op = 8'h00;
          send_byte(op);
          err_exp++;
          idle(2);
        end
      endcase
      drain();
    end

    // Reset while waiting for the final write-data byte.
    ack_mode = 1;
    ready_mode = 1;
    do_en(1'b0);
    drain();
    w0 = we_cnt;
    send_byte(8'h01); send_byte(8'h33); send_byte(8'h12);
    reset = 1'b1;
    exp_sys_en = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(10);
    chk("rst_mid_no_we", 32'(we_cnt), 32'(w0));
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_sys_en", 32'(sys_en), 32'd1);
    do_write(8'h07, 8'h03, 8'h21);
    drain();
    chk("post_rst_wdata", 32'(last_acc.data), 32'h0321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter NEURON_NUMBER, default 256, neuron count; address width AW = clog2(NEURON_NUMBER), AW <= 8.
REQ-002 SHALL have parameter NEUR_WIDTH, default 13, neuron word width, 9..16.
REQ-003 SHALL have parameter GAP_CYCLES, default 100000, maximum inter-byte gap within a frame.
REQ-004 SHALL have parameter SYS_EN_RST, default 1, sys_en value after reset.
REQ-005 SHALL use a single clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1: system clock.
REQ-007 Port reset, input, 1: synchronous active-high reset.
REQ-008 Port rx_valid, input, 1: one-cycle strobe, byte present on rx_data.
REQ-009 Port rx_data, input, 8: received UART byte.
REQ-010 Port ext_req, output, 1: request for neuron memory access.
REQ-011 Port ext_ack, input, 1: access granted by the neuron module.
REQ-012 Port ext_we / ext_re, output, 1 each: write / read strobes.
REQ-013 Port ext_neur_addr, output, AW: neuron address.
REQ-014 Port ext_neur_data_in, output, NEUR_WIDTH: write data.
REQ-015 Port ext_neur_data_out, input, NEUR_WIDTH: read data.
REQ-016 Port sys_en, output, 1: neuron update enable.
REQ-017 Port tx_data, output, 8: response byte.
REQ-018 Port tx_valid, output, 1: response byte valid.
REQ-019 Port tx_ready, input, 1: transmitter accepts the byte; transfer occurs when tx_valid and tx_ready are both high.
REQ-020 Port cmd_err, output, 1: one-cycle pulse on a protocol error.

Function
REQ-021 Frames SHALL be defined as follows:
- WRITE: 0x01, addr, data_hi, data_lo.
- READ: 0x02, addr.
- ENABLE: 0x03.
- DISABLE: 0x04.
REQ-022 The address SHALL be addr[AW-1:0]; write data SHALL be {data_hi,data_lo}[NEUR_WIDTH-1:0]; unused high bits SHALL be ignored.
REQ-023 The FSM SHALL have states IDLE, ADDR, DHI, DLO, REQ, ACCESS, CAPTURE, RESP, with these transitions:
- IDLE: 0x01/0x02 -> ADDR; 0x03/0x04 -> RESP.
- ADDR: WRITE -> DHI; READ -> REQ.
- DHI -> DLO.
- DLO -> REQ.
- REQ: when ext_ack=1 -> ACCESS.
- ACCESS: WRITE -> RESP; READ -> CAPTURE.
- CAPTURE -> RESP.
- RESP: last byte accepted -> IDLE.
REQ-024 ext_req SHALL be high throughout REQ, ACCESS and CAPTURE, and low otherwise.
REQ-025 ext_we (WRITE) or ext_re (READ) SHALL be high for exactly the single ACCESS cycle, with addr and data stable from REQ through CAPTURE.
REQ-026 Read data SHALL be sampled from ext_neur_data_out in CAPTURE, one cycle after ext_re.
REQ-027 ENABLE/DISABLE SHALL set/clear sys_en on the cycle after the opcode byte.
REQ-028 Responses SHALL be:
- WRITE: 0xAA.
- READ: data_hi then data_lo, zero-extended to 16 bits.
- ENABLE/DISABLE: 0xAA.
REQ-029 tx_valid SHALL hold and tx_data stay stable until tx_ready; the next byte SHALL be presented no earlier than the cycle after a transfer.
REQ-030 An unknown opcode in IDLE SHALL pulse cmd_err, the byte SHALL be dropped, and the FSM SHALL stay in IDLE (no response).
REQ-031 rx_valid in any state from REQ through RESP SHALL drop the byte and pulse cmd_err.
REQ-032 A gap counter SHALL run in ADDR/DHI/DLO, clear on each rx_valid, and on reaching GAP_CYCLES SHALL return the FSM to IDLE with a cmd_err pulse (resync).
REQ-033 The gap counter SHALL saturate and never wrap.
REQ-034 ext_ack held low SHALL keep the FSM in REQ indefinitely (no timeout).
REQ-035 ext_ack going high in the same cycle REQ is entered SHALL be honoured on that cycle: ACCESS follows next.

Reset
REQ-036 Reset SHALL force the FSM to IDLE and clear the gap counter.
REQ-037 Reset SHALL drive ext_req, ext_we, ext_re, tx_valid and cmd_err to 0, ext_neur_addr/data_in and tx_data to 0, and sys_en to SYS_EN_RST.
REQ-038 Reset mid-frame or mid-access SHALL abandon the frame with no partial write and no response.

Structure
REQ-039 Opcode constants (0x01-0x04), ACK byte 0xAA and the FSM state enum SHALL reside in a shared package, uart_cmd_pkg.
REQ-040 The block SHALL be a single module with no sub-modules; the gap counter is inline.

Verification
REQ-041 WRITE: bytes 01,05,1F,FF with ext_ack=1 -> one ext_we pulse, addr=0x05, data=0x1FFF; tx byte 0xAA.
REQ-042 READ: 02,10 with ext_neur_data_out=0x0ABC -> one ext_re pulse, addr=0x10; tx bytes 0x0A, 0xBC in order.
REQ-043 ext_ack withheld 50 cycles during WRITE -> ext_req high for 50+ cycles, ext_we low until ack, then exactly one ext_we pulse.
REQ-044 Bytes 01,05 then no byte for GAP_CYCLES -> cmd_err pulse, FSM in IDLE; a following READ completes correctly.
REQ-045 Bytes 07, then 04 -> cmd_err on 07; sys_en 1->0 after 04; tx byte 0xAA; with tx_ready held low 20 cycles, tx_data stays stable.
REQ-046 Reset asserted in DLO -> no ext_we, no tx_valid, sys_en = SYS_EN_RST.
